slice_bank_fifo: RTL and testbench

SLICE_BANK_FIFO -- requirements
Module: slice_bank_fifo

---
 rtl/slice_bank_fifo.sv | 164 ++++++++++++++++
 tb/tb_slice_bank_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_bank_fifo.sv
// rtl/slice_bank_fifo.sv - banked slice FIFO between a slice writer and a frame reader
//
// Purpose: NBANKS RAM banks of 2**ADDR_W words form a ring of slice buffers.
//   The writer fills the bank at (head + level) and commits it with a slice
//   number; the reader claims the oldest committed bank (head) with rstart,
//   reads it at random addresses, and releases it with rdone.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   i_flush                    synchronous clear of pointers, counters and flags
//   i_wen/i_waddr/i_wdata      write into the current write bank
//   i_wcommit/i_wslice         commit the write bank as slice i_wslice
//   i_rstart/i_rslice          reader claims the head bank as slice i_rslice
//   o_rstart_ack               combinational acceptance of i_rstart
//   i_rdone                    reader releases the head bank
//   i_raddr/o_rdata            head-bank read address, registered read data
//   o_level/o_empty/o_full     committed banks held and derived status
//   o_reading                  head bank currently claimed by the reader
//   o_overflow/o_seq_err       sticky error flags
module slice_bank_fifo #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 8,
    parameter int NBANKS  = 8,
    parameter int NSLICES = 128
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          i_flush,
    input  logic                          i_wen,
    input  logic [ADDR_W-1:0]             i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic                          i_wcommit,
    input  logic [7:0]                    i_wslice,
    input  logic                          i_rstart,
    input  logic [7:0]                    i_rslice,
    output logic                          o_rstart_ack,
    input  logic                          i_rdone,
    input  logic [ADDR_W-1:0]             i_raddr,
    output logic [DATA_W-1:0]             o_rdata,
    output logic [$clog2(NBANKS+1)-1:0]   o_level,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_reading,
    output logic                          o_overflow,
    output logic                          o_seq_err
);

    localparam int BANK_W = $clog2(NBANKS);
    localparam int LVL_W  = $clog2(NBANKS+1);
    localparam int DEPTH  = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [NBANKS*DEPTH];

    logic [BANK_W-1:0] r_head;
    logic [LVL_W-1:0]  r_level;
    logic [7:0]        r_exp_w;
    logic [7:0]        r_exp_r;
    logic              r_reading;
    logic              r_overflow;
    logic              r_seq_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_full;
    logic              w_empty;
    logic [BANK_W-1:0] w_wbank;
    logic              w_wr_en;
    logic              w_wr_drop;
    logic              w_commit_ok;
    logic              w_commit_full;
    logic              w_commit_seq;
    logic              w_start_ok;
    logic              w_done_ok;

    function automatic logic [7:0] slice_inc(input logic [7:0] s);
        return (s == 8'(NSLICES-1)) ? 8'd0 : s + 8'd1;
    endfunction

    assign w_full  = (r_level == LVL_W'(NBANKS));
    assign w_empty = (r_level == '0);

    // NBANKS is a power of two, so dropping the level MSB is the modulo.
    // When full this aliases head, but every write is then discarded.
    assign w_wbank = r_head + r_level[BANK_W-1:0];

    assign w_wr_en       = !i_flush && i_wen && !w_full;
    assign w_wr_drop     = !i_flush && i_wen && w_full;
    assign w_commit_full = !i_flush && i_wcommit && w_full;
    assign w_commit_ok   = !i_flush && i_wcommit && !w_full && (i_wslice == r_exp_w);
    assign w_commit_seq  = !i_flush && i_wcommit && !w_full && (i_wslice != r_exp_w);

    // rstart is evaluated against the current reading flag, so an rstart in
    // the same cycle as rdone is refused and must be retried next cycle.
    assign w_start_ok = !i_flush && i_rstart && !r_reading && !w_empty
                        && (i_rslice == r_exp_r);
    assign w_done_ok  = !i_flush && i_rdone && r_reading;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{w_wbank, i_waddr}] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[{r_head, i_raddr}];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_head     <= '0;
            r_level    <= '0;
            r_exp_w    <= '0;
            r_exp_r    <= '0;
            r_reading  <= 1'b0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else if (i_flush) begin
            r_head     <= '0;
            r_level    <= '0;
            r_exp_w    <= '0;
            r_exp_r    <= '0;
            r_reading  <= 1'b0;
            r_overflow <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            if (w_wr_drop || w_commit_full) begin
                r_overflow <= 1'b1;
            end
            // A mis-numbered commit leaves the write bank in place; the next
            // slice simply overwrites it.
            if (w_commit_seq) begin
                r_seq_err <= 1'b1;
            end
            if (w_commit_ok) begin
                r_exp_w <= slice_inc(r_exp_w);
            end
            if (w_start_ok) begin
                r_reading <= 1'b1;
                r_exp_r   <= slice_inc(r_exp_r);
            end
            if (w_done_ok) begin
                r_reading <= 1'b0;
                r_head    <= r_head + BANK_W'(1);
            end
            case ({w_commit_ok, w_done_ok})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rstart_ack = w_start_ok;
    assign o_rdata      = r_rdata;
    assign o_level      = r_level;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_reading    = r_reading;
    assign o_overflow   = r_overflow;
    assign o_seq_err    = r_seq_err;

endmodule

// File: tb/tb_slice_bank_fifo.sv
// tb/tb_slice_bank_fifo.sv - self-checking bench for slice_bank_fifo
module tb_slice_bank_fifo;

    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 8;
    localparam int NBANKS  = 8;
    localparam int NSLICES = 128;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk;
    logic              nrst;
    logic              i_flush;
    logic              i_wen;
    logic [ADDR_W-1:0] i_waddr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_wcommit;
    logic [7:0]        i_wslice;
    logic              i_rstart;
    logic [7:0]        i_rslice;
    logic              o_rstart_ack;
    logic              i_rdone;
    logic [ADDR_W-1:0] i_raddr;
    logic [DATA_W-1:0] o_rdata;
    logic [3:0]        o_level;
    logic              o_empty;
    logic              o_full;
    logic              o_reading;
    logic              o_overflow;
    logic              o_seq_err;

    int n_vec = 0;
    int n_bad = 0;

    slice_bank_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NBANKS(NBANKS), .NSLICES(NSLICES)
    ) dut (
        .clk(clk), .nrst(nrst), .i_flush(i_flush),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wcommit(i_wcommit), .i_wslice(i_wslice),
        .i_rstart(i_rstart), .i_rslice(i_rslice), .o_rstart_ack(o_rstart_ack),
        .i_rdone(i_rdone), .i_raddr(i_raddr), .o_rdata(o_rdata),
        .o_level(o_level), .o_empty(o_empty), .o_full(o_full),
        .o_reading(o_reading), .o_overflow(o_overflow), .o_seq_err(o_seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] pix(input int s, input int a);
        return {8'(s), 8'(a), 8'h5A};
    endfunction

    // Behavioural model: a FIFO of slice buffers held in a plain bank array,
    // with the write buffer at (head + level) mod NBANKS.
    int               m_head, m_level, m_expw, m_expr;
    bit               m_reading, m_ovf, m_seq;
    logic [DATA_W-1:0] m_mem [NBANKS][DEPTH];
    bit               m_wr [NBANKS][DEPTH];
    logic [DATA_W-1:0] m_rdata;
    bit               m_rdv;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_head = 0; m_level = 0; m_expw = 0; m_expr = 0;
            m_reading = 0; m_ovf = 0; m_seq = 0;
            m_rdata = '0; m_rdv = 1;
        end else begin
            bit full, c_ok, s_ok, d_ok;
            int wb;
            m_rdata = m_mem[m_head][i_raddr];
            m_rdv   = m_wr[m_head][i_raddr];
            if (i_flush) begin
                m_head = 0; m_level = 0; m_expw = 0; m_expr = 0;
                m_reading = 0; m_ovf = 0; m_seq = 0;
            end else begin
                full = (m_level == NBANKS);
                wb   = (m_head + m_level) % NBANKS;
                if (i_wen) begin
                    if (full) m_ovf = 1;
                    else begin
                        m_mem[wb][i_waddr] = i_wdata;
                        m_wr[wb][i_waddr]  = 1;
                    end
                end
                c_ok = 0;
                if (i_wcommit) begin
                    if (full) m_ovf = 1;
                    else if (int'(i_wslice) == m_expw) begin
                        c_ok = 1;
                        m_expw = (m_expw + 1) % NSLICES;
                    end else m_seq = 1;
                end
                s_ok = i_rstart && !m_reading && m_level > 0 && int'(i_rslice) == m_expr;
                d_ok = i_rdone && m_reading;
                if (s_ok) begin m_reading = 1; m_expr = (m_expr + 1) % NSLICES; end
                if (d_ok) begin m_reading = 0; m_head = (m_head + 1) % NBANKS; end
                m_level = m_level + int'(c_ok) - int'(d_ok);
            end
        end
    end

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        bit exp_ack;
        exp_ack = !i_flush && i_rstart && !m_reading && m_level > 0
                  && int'(i_rslice) == m_expr;
        chk("ack",      32'(o_rstart_ack), 32'(exp_ack));
        chk("level",    32'(o_level),      32'(m_level));
        chk("empty",    32'(o_empty),      32'(m_level == 0));
        chk("full",     32'(o_full),       32'(m_level == NBANKS));
        chk("reading",  32'(o_reading),    32'(m_reading));
        chk("overflow", 32'(o_overflow),   32'(m_ovf));
        chk("seq_err",  32'(o_seq_err),    32'(m_seq));
        if (m_rdv) chk("rdata", 32'(o_rdata), 32'(m_rdata));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_flush = 0; i_wen = 0; i_wcommit = 0; i_rstart = 0; i_rdone = 0;
    endtask

    task automatic write_slice(input int s);
        for (int a = 0; a < 4; a++) begin
            i_wen = 1; i_waddr = 8'(a); i_wdata = pix(s, a);
            tick();
        end
        i_wcommit = 1; i_wslice = 8'(s);
        tick();
    endtask

    task automatic do_flush();
        i_flush = 1;
        tick();
    endtask

    initial begin
        nrst = 0; i_flush = 0; i_wen = 0; i_waddr = '0; i_wdata = '0;
        i_wcommit = 0; i_wslice = '0; i_rstart = 0; i_rslice = '0;
        i_rdone = 0; i_raddr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_ack",   32'(o_rstart_ack), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        nrst = 1;
        tick();

        // basic write 0..3, read slice 0
        for (int s = 0; s < 4; s++) write_slice(s);
        chk("b_level4", 32'(o_level), 32'd4);
        i_rstart = 1; i_rslice = 8'd0;
        #1 chk("b_ack", 32'(o_rstart_ack), 32'd1);
        tick();
        i_raddr = 8'd3;
        tick();
        chk("b_rdata", 32'(o_rdata), 32'h00035A);
        i_rdone = 1;
        tick();
        chk("b_level3", 32'(o_level), 32'd3);

        // fill to full, overflow, recover
        do_flush();
        for (int s = 0; s < 8; s++) write_slice(s);
        chk("f_full", 32'(o_full), 32'd1);
        i_wcommit = 1; i_wslice = 8'd8;
        tick();
        chk("f_ovf",    32'(o_overflow), 32'd1);
        chk("f_level8", 32'(o_level), 32'd8);
        i_rstart = 1; i_rslice = 8'd0;
        tick();
        i_rdone = 1;
        tick();
        chk("f_level7", 32'(o_level), 32'd7);
        write_slice(8);
        chk("f_relevel8", 32'(o_level), 32'd8);

        // sequence error then recovery
        do_flush();
        for (int a = 0; a < 4; a++) begin
            i_wen = 1; i_waddr = 8'(a); i_wdata = pix(5, a);
            tick();
        end
        i_wcommit = 1; i_wslice = 8'd5;
        tick();
        chk("s_seq",    32'(o_seq_err), 32'd1);
        chk("s_level0", 32'(o_level), 32'd0);
        write_slice(0);
        chk("s_level1", 32'(o_level), 32'd1);
        i_rstart = 1; i_rslice = 8'd0; i_raddr = 8'd2;
        tick();
        tick();
        chk("s_rdata", 32'(o_rdata), 32'h00025A);

        // same-cycle commit + rdone, rstart refused alongside rdone
        do_flush();
        for (int s = 0; s < 3; s++) write_slice(s);
        i_rstart = 1; i_rslice = 8'd0;
        tick();
        for (int a = 0; a < 4; a++) begin
            i_wen = 1; i_waddr = 8'(a); i_wdata = pix(3, a);
            tick();
        end
        i_wcommit = 1; i_wslice = 8'd3; i_rdone = 1; i_rstart = 1; i_rslice = 8'd1;
        #1 chk("c_ack0", 32'(o_rstart_ack), 32'd0);
        tick();
        chk("c_level3", 32'(o_level), 32'd3);
        i_rstart = 1; i_rslice = 8'd1; i_raddr = 8'd0;
        #1 chk("c_ack1", 32'(o_rstart_ack), 32'd1);
        tick();
        chk("c_rdata_head1", 32'(o_rdata), 32'h01005A);

        // flush while reading with overflow set
        do_flush();
        for (int s = 0; s < 8; s++) write_slice(s);
        i_wen = 1; i_waddr = 8'd0; i_wdata = 24'hFFFFFF;
        tick();
        for (int s = 0; s < 3; s++) begin
            i_rstart = 1; i_rslice = 8'(s);
            tick();
            i_rdone = 1;
            tick();
        end
        i_rstart = 1; i_rslice = 8'd3;
        tick();
        chk("x_level5", 32'(o_level), 32'd5);
        chk("x_ovf",    32'(o_overflow), 32'd1);
        do_flush();
        chk("x_level0",  32'(o_level), 32'd0);
        chk("x_reading", 32'(o_reading), 32'd0);
        chk("x_ovf0",    32'(o_overflow), 32'd0);
        chk("x_empty",   32'(o_empty), 32'd1);

        // 130 slices with slice-number wrap
        do_flush();
        for (int i = 0; i < 130; i++) begin
            write_slice(i % NSLICES);
            i_rstart = 1; i_rslice = 8'(i % NSLICES);
            #1 chk("w_ack", 32'(o_rstart_ack), 32'd1);
            tick();
            for (int a = 0; a < 4; a++) begin
                i_raddr = 8'(a);
                tick();
                if (i == 129 && a == 2) chk("w_rdata_wrap", 32'(o_rdata), 32'h01025A);
            end
            i_rdone = 1;
            tick();
        end
        chk("w_seq0",   32'(o_seq_err), 32'd0);
        chk("w_ovf0",   32'(o_overflow), 32'd0);
        chk("w_level0", 32'(o_level), 32'd0);

        // asynchronous reset mid-frame
        write_slice(2);
        write_slice(3);
        i_rstart = 1; i_rslice = 8'd2;
        tick();
        #2 nrst = 0;
        #1;
        chk("r_level0",  32'(o_level), 32'd0);
        chk("r_empty",   32'(o_empty), 32'd1);
        chk("r_reading", 32'(o_reading), 32'd0);
        chk("r_rdata",   32'(o_rdata), 32'd0);
        @(posedge clk);
        #1 nrst = 1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
